// File: rtl/reg_pkg.sv
// reg_pkg: shared register-file geometry and dump-reader state encoding.
`timescale 1ns/1ps
package reg_pkg;
    localparam int REG_AW  = 5;
    localparam int REG_NUM = 32;
    localparam int REG_DW  = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, SEND = 2'd2, FIN = 2'd3} state_t;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks Ra over a latched register range and streams each value out over valid/ready.
`timescale 1ns/1ps
module reg_dump_reader
    import reg_pkg::*;
#(
    parameter int n  = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] FirstReg,
    input  logic [AW-1:0] LastReg,
    output logic [AW-1:0] Ra,
    input  logic [n-1:0]  busA,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [n-1:0]  OutData,
    output logic [AW-1:0] OutIdx,
    output logic          Busy,
    output logic          Done
);
    state_t        state_q, state_d;
    logic [AW-1:0] ra_q, ra_d, last_q, last_d, idx_q, idx_d;
    logic [n-1:0]  data_q, data_d;
    logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            ra_q    <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Ra stays put through READ so a negedge write to that register lands in the capture.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        last_d  = last_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (Start) begin
                last_d  = LastReg;
                ra_d    = FirstReg;
                busy_d  = 1'b1;
                state_d = READ;
            end
            READ: begin
                data_d  = busA;
                idx_d   = ra_q;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: if (OutReady) begin
                valid_d = 1'b0;
                state_d = (idx_q == last_q) ? FIN : READ;
                ra_d    = (idx_q == last_q) ? ra_q : ra_q + AW'(1);
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Ra       = ra_q;
    assign OutValid = valid_q;
    assign OutData  = data_q;
    assign OutIdx   = idx_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: register-file model plus scoreboard of expected (index, value) beats.
`timescale 1ns/1ps
module tb_reg_dump_reader;
    logic        Clock = 1'b0, Reset = 1'b1, Start = 1'b0, OutReady = 1'b0, RegWr = 1'b0;
    logic        OutValid, Busy, Done;
    logic [4:0]  FirstReg = '0, LastReg = '0, WrAddr = '0, Ra, OutIdx;
    logic [31:0] WrData = '0, busA, OutData;
    logic [31:0] regs [32];

    typedef struct packed {logic [4:0] idx; logic [31:0] data;} beat_t;
    beat_t exp_q[$];
    beat_t e;

    int vectors = 0, miscompares = 0;
    int rdy_mode = 0, hold_cnt = 0, done_cnt = 0, beats = 0, stall_cnt = 0, cyc = 0, last_acc = 0;
    bit wr_arm = 1'b0, stall_q = 1'b0;
    logic [4:0]  st_idx;
    logic [31:0] st_data;

    reg_dump_reader #(.n(32), .AW(5)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .FirstReg(FirstReg), .LastReg(LastReg),
        .Ra(Ra), .busA(busA), .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutIdx(OutIdx), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Register file: combinational read, write on the falling edge.
    assign busA = regs[Ra];
    always @(negedge Clock) if (RegWr) regs[WrAddr] <= WrData;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    always @(posedge Clock) begin
        cyc++;
        #2;
        if (rdy_mode == 0) OutReady = 1'b1;
        else if (rdy_mode == 1) OutReady = ~OutReady;
        else begin
            if (OutValid) hold_cnt++;
            OutReady = hold_cnt > 6;
        end
        RegWr = wr_arm && Busy && !OutValid && Ra == 5'd7;
        if (RegWr) begin
            WrAddr = 5'd7;
            WrData = 32'hDEAD;
            wr_arm = 1'b0;
        end
    end

    always @(negedge Clock) begin
        if (Done) done_cnt++;
        if (stall_q) begin
            check("hold_valid", OutValid, 1);
            check("hold_idx", OutIdx, st_idx);
            check("hold_data", OutData, st_data);
        end
        stall_q = OutValid && !OutReady && !Reset;
        if (stall_q) stall_cnt++;
        st_idx  = OutIdx;
        st_data = OutData;
        if (OutValid && OutReady) begin
            if (exp_q.size() == 0) check("extra_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("beat_idx", OutIdx, e.idx);
                check("beat_data", OutData, e.data);
            end
            if (rdy_mode == 0 && beats > 0) check("beat_gap", cyc - last_acc, 2);
            beats++;
            last_acc = cyc;
        end
    end

    task automatic run_dump(input logic [4:0] first, input logic [4:0] last, input int mode,
                            input bit mid, input bit lat);
        logic [4:0] d;
        int cnt;
        bit got;
        d   = last - first;
        cnt = int'(d) + 1;
        rdy_mode = mode; hold_cnt = 0; done_cnt = 0; beats = 0; stall_cnt = 0;
        for (int i = 0; i < cnt; i++) begin
            logic [4:0] a;
            a = first + 5'(i);
            exp_q.push_back({a, (wr_arm && a == 5'd7) ? 32'hDEAD : regs[a]});
        end
        @(negedge Clock);
        Start = 1'b1; FirstReg = first; LastReg = last;
        @(posedge Clock);
        #1;
        Start = 1'b0; FirstReg = ~first; LastReg = ~last;
        check("busy_set", Busy, 1);
        if (lat) begin
            check("lat_k", OutValid, 0);
            @(posedge Clock);
            #1 check("lat_k1", OutValid, 1);
        end
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge Clock);
            if (mid && c == 20) begin Start = 1'b1; FirstReg = 5'd3; LastReg = 5'd3; end
            if (mid && c == 21) Start = 1'b0;
            if (Done) got = 1'b1;
        end
        Start = 1'b0;
        check("done_seen", got, 1);
        check("q_empty", exp_q.size(), 0);
        check("beat_count", beats, cnt);
        @(negedge Clock);
        check("done_once", done_cnt, 1);
        check("busy_clr", Busy, 0);
        check("done_clr", Done, 0);
        exp_q.delete();
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_ra", Ra, 0);
        check("rst_valid", OutValid, 0);
        check("rst_data", OutData, 0);
        check("rst_idx", OutIdx, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset = 1'b0;
        repeat (2) @(posedge Clock);

        run_dump(5'd1, 5'd3, 0, 1'b0, 1'b1);
        run_dump(5'd30, 5'd1, 0, 1'b0, 1'b0);
        run_dump(5'd5, 5'd5, 2, 1'b0, 1'b0);
        check("stall_cycles", stall_cnt, 6);
        run_dump(5'd0, 5'd31, 1, 1'b1, 1'b0);
        wr_arm = 1'b1;
        run_dump(5'd6, 5'd8, 0, 1'b0, 1'b0);
        check("wr_consumed", wr_arm, 0);

        rdy_mode = 0; done_cnt = 0; beats = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), regs[i]});
        @(negedge Clock);
        Start = 1'b1; FirstReg = 5'd0; LastReg = 5'd31;
        @(negedge Clock);
        Start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge Clock);
            if (OutValid && OutIdx == 5'd10) hit = 1'b1;
        end
        check("reach_reg10", hit, 1);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("mid_rst_valid", OutValid, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_ra", Ra, 0);
        Reset = 1'b0;
        exp_q.delete();
        done_cnt = 0;
        repeat (3) @(negedge Clock);
        check("mid_rst_no_done", done_cnt, 0);
        run_dump(5'd0, 5'd0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side engine for the 32x32 register file. It walks the read address through a programmed register range and streams each register value out over a valid/ready interface.
- Sits between the register file's read port A (drives Ra, samples busA) and the debug/trace path, for example a UART dumper or a testbench scoreboard.
- Replaces ad-hoc $display dumps with a hardware-visible register snapshot.

Parameters:
- n, 32, data width of busA and OutData
- AW, 5, register address width; register count is 2**AW

Ports:
- Clock  input  1  single system clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- FirstReg  input  AW  first register index; latched on accepted Start
- LastReg  input  AW  last register index, inclusive; latched on accepted Start
- Ra  output  AW  read address to the register file port A
- busA  input  n  combinational read data from the register file for Ra
- OutValid  output  1  OutData/OutIdx hold a valid beat
- OutReady  input  1  consumer accepts the beat when OutValid && OutReady at posedge
- OutData  output  n  captured register value
- OutIdx  output  AW  index of the register in OutData
- Busy  output  1  high from accepted Start until Done
- Done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Clocking and reset: one clock, Clock; reset is synchronous and active-high, port Reset.
- Reset values: Ra=0, OutValid=0, OutData=0, OutIdx=0, Busy=0, Done=0, state=IDLE, latched last=0.
- States: IDLE, READ, SEND, FIN.
- IDLE:
  - Start=1 at posedge: latch LastReg, set Ra<=FirstReg, Busy<=1, go to READ.
  - Start=0: stay in IDLE. Ra holds its last value.
- READ:
  - Ra is held stable for one full cycle.
  - At posedge: OutData<=busA, OutIdx<=Ra, OutValid<=1, go to SEND.
  - The register file writes on the falling edge, so a write to Ra at the negedge inside the READ cycle is included in the captured value.
- SEND:
  - OutValid, OutData, OutIdx, Ra hold stable until a handshake occurs.
  - On handshake with OutIdx==last: OutValid<=0, go to FIN.
  - On handshake otherwise: OutValid<=0, Ra<=Ra+1 (mod 2**AW), go to READ.
  - OutValid never drops without a handshake, except on Reset.
- FIN: Done<=1 for exactly one cycle, Busy<=0, return to IDLE.
- Latency: Start accepted at edge k. First OutValid is high after edge k+1. Minimum 2 cycles per register when OutReady=1.
- Range rules:
  - FirstReg==LastReg: exactly 1 beat.
  - FirstReg>LastReg: the address wraps 31->0 and continues to LastReg. Beat count = ((LastReg-FirstReg) mod 32)+1.
  - Full dump is First=0, Last=31, 32 beats.
- Start while Busy: ignored. FirstReg/LastReg changes while Busy: no effect.
- Reset mid-dump: returns to IDLE at that edge. OutValid drops immediately, no Done pulse, partial dump discarded.
- No combinational path from OutReady or busA to any output; all outputs are registered.

Decomposition:
- Shared package reg_pkg holds:
  - REG_AW=5, REG_NUM=32, REG_DW=32
  - the state enumeration IDLE/READ/SEND/FIN, 2-bit encoding 0..3
- Single flat module; no sub-module. The address counter and capture register are too small to split out.
- Bench instantiates the existing register file module with reg_dump_reader driving its Ra and consuming busA.

Test Plan:
- Preload reg1=32'h11, reg2=32'h22, reg3=32'h33. Start with First=1, Last=3, OutReady=1 -> beats (1,h11),(2,h22),(3,h33), one every 2 cycles. First OutValid 2 edges after Start. Done pulses once, Busy low after.
- First=30, Last=1, OutReady=1 -> OutIdx sequence 30,31,0,1, exactly 4 beats, Done once.
- First=5, Last=5, OutReady held 0 for 6 cycles, then 1 -> OutValid stays high with OutIdx=5 and stable data for 6 cycles. One beat, then Done.
- Full dump 0..31 with OutReady toggling 1,0,1,0 -> 32 beats in order, no duplicates or drops. Start pulsed mid-dump has no effect.
- Register-file write of 32'hDEAD to reg7 (RegWr=1) on the negedge during the READ cycle for reg7 -> beat (7,hDEAD).
- Reset asserted while in SEND at reg 10 of a 0..31 dump -> next cycle OutValid=0, Busy=0, Ra=0, no Done. A following Start with First=0, Last=0 yields a single beat (0,h0).
